// File: rtl/mem_arb_pkg.sv
// Shared types, defaults and arbitration helper for the two-requester memory arbiter.
package mem_arb_pkg;

  localparam int unsigned AwDef      = 16;
  localparam int unsigned DwDef      = 16;
  localparam int unsigned NbankDef   = 4;
  localparam int unsigned TimeoutDef = 64;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StOwn0  = 2'd1,
    StOwn1  = 2'd2,
    StDrain = 2'd3
  } arb_state_e;

  // Round-robin pick: on a tie the requester that did not own the memory last wins.
  function automatic arb_state_e arbitrate(input logic r0, input logic r1, input logic last_owner);
    if (r0 && r1) return last_owner ? StOwn0 : StOwn1;
    else if (r0)  return StOwn0;
    else if (r1)  return StOwn1;
    else          return StIdle;
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Grant-hold watchdog: saturating counter with synchronous clear, flags expiry at Timeout-1.
module mem_arb_watchdog #(
  parameter int unsigned Timeout = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CntW = $clog2(Timeout + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(Timeout - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign expire_o = en_i && (cnt_q == CntMax);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (I-side / D-side) arbiter for a banked memory with drain and watchdog.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW      = AwDef,
  parameter int unsigned DW      = DwDef,
  parameter int unsigned NBANK   = NbankDef,
  parameter int unsigned TIMEOUT = TimeoutDef
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [AW-1:0]    addr0,
  input  logic [AW-1:0]    addr1,
  input  logic [DW-1:0]    data_in0,
  input  logic [DW-1:0]    data_in1,
  input  logic             wr0,
  input  logic             rd0,
  input  logic             wr1,
  input  logic             rd1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [DW-1:0]    data_out0,
  output logic [DW-1:0]    data_out1,
  output logic             stall0,
  output logic             stall1,
  output logic             err0,
  output logic             err1,
  output logic [AW-1:0]    m_addr,
  output logic [DW-1:0]    m_data_in,
  output logic             m_wr,
  output logic             m_rd,
  input  logic [DW-1:0]    m_data_out,
  input  logic [NBANK-1:0] m_busy,
  input  logic             m_stall,
  input  logic             m_err
);

  arb_state_e state_d, state_q;
  logic       last_owner_d, last_owner_q;
  logic       mem_idle, wd_en, wd_clr, expire;

  assign mem_idle = (m_busy == '0);
  assign wd_en    = (state_q == StOwn0) || (state_q == StOwn1);
  // A same-owner re-grant after expiry is not a state change, so expiry also clears.
  assign wd_clr   = (state_d != state_q) || expire;

  mem_arb_watchdog #(
    .Timeout (TIMEOUT)
  ) u_watchdog (
    .clk_i    (clk),
    .rst_ni   (rst),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expire_o (expire)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = arbitrate(req0, req1, last_owner_q);
      StOwn0: begin
        if (!req0 || expire) state_d = mem_idle ? arbitrate(req0, req1, last_owner_q) : StDrain;
      end
      StOwn1: begin
        if (!req1 || expire) state_d = mem_idle ? arbitrate(req0, req1, last_owner_q) : StDrain;
      end
      StDrain: begin
        if (mem_idle) state_d = arbitrate(req0, req1, last_owner_q);
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    last_owner_d = last_owner_q;
    if (state_d == StOwn0) last_owner_d = 1'b0;
    if (state_d == StOwn1) last_owner_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Write wins a wr+rd conflict; a release coinciding with expiry raises no watchdog error.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    m_addr    = '0;
    m_data_in = '0;
    m_wr      = 1'b0;
    m_rd      = 1'b0;
    data_out0 = '0;
    data_out1 = '0;
    stall0    = req0;
    stall1    = req1;
    err0      = 1'b0;
    err1      = 1'b0;
    unique case (state_q)
      StOwn0: begin
        gnt0      = 1'b1;
        m_addr    = addr0;
        m_data_in = data_in0;
        m_wr      = wr0;
        m_rd      = rd0 & ~wr0;
        data_out0 = m_data_out;
        stall0    = m_stall;
        err0      = m_err | (expire & req0) | (wr0 & rd0);
      end
      StOwn1: begin
        gnt1      = 1'b1;
        m_addr    = addr1;
        m_data_in = data_in1;
        m_wr      = wr1;
        m_rd      = rd1 & ~wr1;
        data_out1 = m_data_out;
        stall1    = m_stall;
        err1      = m_err | (expire & req1) | (wr1 & rd1);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: grant, round-robin, drain, watchdog, reset.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, wr0, rd0, wr1, rd1;
  logic [15:0] addr0, addr1, data_in0, data_in1;
  logic        gnt0, gnt1, stall0, stall1, err0, err1, m_wr, m_rd;
  logic [15:0] data_out0, data_out1, m_addr, m_data_in, m_data_out;
  logic [3:0]  m_busy;
  logic        m_stall, m_err;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0       (req0),
    .req1       (req1),
    .addr0      (addr0),
    .addr1      (addr1),
    .data_in0   (data_in0),
    .data_in1   (data_in1),
    .wr0        (wr0),
    .rd0        (rd0),
    .wr1        (wr1),
    .rd1        (rd1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .data_out0  (data_out0),
    .data_out1  (data_out1),
    .stall0     (stall0),
    .stall1     (stall1),
    .err0       (err0),
    .err1       (err1),
    .m_addr     (m_addr),
    .m_data_in  (m_data_in),
    .m_wr       (m_wr),
    .m_rd       (m_rd),
    .m_data_out (m_data_out),
    .m_busy     (m_busy),
    .m_stall    (m_stall),
    .m_err      (m_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    #1;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    {req0, req1, wr0, rd0, wr1, rd1} = '0;
    {addr0, addr1, data_in0, data_in1, m_data_out} = '0;
    m_busy = '0; m_stall = 1'b0; m_err = 1'b0;
    #1;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    req1 = 1'b1;
    #1;
    chk("rst_stall1", stall1, 1);
    chk("rst_gnt1_req", gnt1, 0);
    chk("rst_m_rd", m_rd, 0);
    chk("rst_m_addr", m_addr, 0);
    req1 = 1'b0;
    tick(); tick();
    rst = 1'b1;

    // Single requester grant latency and mux
    req0 = 1'b1; addr0 = 16'h1234; rd0 = 1'b1; data_in0 = 16'h5A5A;
    #1;
    chk("lat_gnt0_early", gnt0, 0);
    chk("lat_stall0_early", stall0, 1);
    tick();
    chk("lat_gnt0", gnt0, 1);
    chk("lat_m_addr", m_addr, 16'h1234);
    chk("lat_m_rd", m_rd, 1);
    chk("lat_m_wr", m_wr, 0);
    chk("lat_m_data_in", m_data_in, 16'h5A5A);
    chk("lat_stall1", stall1, 0);
    chk("lat_gnt1", gnt1, 0);
    m_data_out = 16'hBEEF; m_stall = 1'b1;
    #1;
    chk("ret_data_out0", data_out0, 16'hBEEF);
    chk("ret_data_out1", data_out1, 0);
    chk("ret_stall0", stall0, 1);
    m_stall = 1'b0;
    #1;
    chk("ret_stall0_low", stall0, 0);
    req0 = 1'b0; rd0 = 1'b0;
    tick();
    chk("rel_gnt0", gnt0, 0);
    chk("rel_m_addr", m_addr, 0);

    // Tie after reset, direct handover, round-robin from idle
    reset_dut();
    req0 = 1'b1; req1 = 1'b1; addr0 = 16'h0100; addr1 = 16'h0300;
    tick();
    chk("tie_gnt0", gnt0, 1);
    chk("tie_gnt1", gnt1, 0);
    chk("tie_stall1", stall1, 1);
    chk("tie_m_addr", m_addr, 16'h0100);
    req0 = 1'b0;
    tick();
    chk("hand_gnt1", gnt1, 1);
    chk("hand_gnt0", gnt0, 0);
    chk("hand_m_addr", m_addr, 16'h0300);
    req1 = 1'b0;
    tick();
    chk("idle_gnt1", gnt1, 0);
    req0 = 1'b1; req1 = 1'b1;
    tick();
    chk("rr_gnt0", gnt0, 1);
    chk("rr_gnt1", gnt1, 0);
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // Drain while banks busy, then strobe conflict on the next owner
    req1 = 1'b1; rd1 = 1'b1; addr1 = 16'h0200;
    tick();
    chk("own1_gnt1", gnt1, 1);
    chk("own1_m_rd", m_rd, 1);
    chk("own1_m_addr", m_addr, 16'h0200);
    m_busy = 4'b0010; req1 = 1'b0; rd1 = 1'b0;
    req0 = 1'b1; rd0 = 1'b1; wr0 = 1'b1; addr0 = 16'h0040;
    tick();
    chk("drain_gnt0", gnt0, 0);
    chk("drain_gnt1", gnt1, 0);
    chk("drain_m_rd", m_rd, 0);
    chk("drain_m_wr", m_wr, 0);
    chk("drain_m_addr", m_addr, 0);
    chk("drain_stall0", stall0, 1);
    tick();
    chk("drain2_gnt0", gnt0, 0);
    chk("drain2_m_wr", m_wr, 0);
    m_busy = 4'b0000;
    #1;
    chk("drain_exit_reg", gnt0, 0);
    tick();
    chk("drain_exit_gnt0", gnt0, 1);
    chk("conf_m_wr", m_wr, 1);
    chk("conf_m_rd", m_rd, 0);
    chk("conf_err0", err0, 1);
    chk("conf_m_addr", m_addr, 16'h0040);
    wr0 = 1'b0;
    #1;
    chk("conf_clear_err0", err0, 0);
    chk("conf_clear_m_rd", m_rd, 1);
    m_err = 1'b1;
    #1;
    chk("merr_err0", err0, 1);
    chk("merr_err1", err1, 0);
    m_err = 1'b0; req0 = 1'b0; rd0 = 1'b0;
    tick();
    chk("conf_rel_gnt0", gnt0, 0);

    // Watchdog: expiry at ownership cycle 64 hands over to the waiting requester
    req0 = 1'b1;
    tick();
    chk("wd_gnt0", gnt0, 1);
    req1 = 1'b1;
    for (int i = 2; i <= 63; i++) begin
      tick();
      chk("wd_no_err0", err0, 0);
    end
    tick();
    chk("wd_err0", err0, 1);
    chk("wd_gnt0_64", gnt0, 1);
    tick();
    chk("wd_gnt1", gnt1, 1);
    chk("wd_gnt0_off", gnt0, 0);
    chk("wd_err0_pulse", err0, 0);
    chk("wd_stall0", stall0, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("wd_hold_gnt1", gnt1, 1);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // Reset mid-fill abandons grant; tie afterwards goes to requester 0
    req1 = 1'b1; rd1 = 1'b1; addr1 = 16'h0700;
    tick();
    chk("mid_gnt1", gnt1, 1);
    chk("mid_m_rd", m_rd, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_gnt1", gnt1, 0);
    chk("mid_rst_m_rd", m_rd, 0);
    chk("mid_rst_m_addr", m_addr, 0);
    chk("mid_rst_stall1", stall1, 1);
    chk("mid_rst_err1", err1, 0);
    tick();
    rst = 1'b1; req0 = 1'b1;
    #1;
    chk("post_rst_gnt1", gnt1, 0);
    chk("post_rst_m_rd", m_rd, 0);
    tick();
    chk("post_rst_gnt0", gnt0, 1);
    chk("post_rst_gnt1_tie", gnt1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
